// File: rtl/wb_cmd_ctl.sv
// Command controller between the Wishbone slave bridge and the toy SRAM array.
// Define TOYSRAM_CFG_REGS_EN to add the local register window at cmd_adr[27:24] == 4'hF.
module wb_cmd_ctl #(
    parameter int ADR_W  = 10,
    parameter int RD_LAT = 2     // legal range 1..7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_val,
    input  logic [31:0]      cmd_adr,
    input  logic             cmd_we,
    input  logic [3:0]       cmd_sel,
    input  logic [31:0]      cmd_dat,
    output logic             rd_ack,
    output logic [31:0]      rd_dat,
    output logic             sram_rd_en,
    output logic             sram_wr_en,
    output logic [ADR_W-1:0] sram_adr,
    output logic [3:0]       sram_wr_sel,
    output logic [31:0]      sram_wr_dat,
    input  logic [31:0]      sram_rd_dat
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    localparam logic [2:0] LAT_LD   = 3'(RD_LAT);
    localparam logic [2:0] DRAIN_LD = 3'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             rd_ack_q, rd_ack_d;
    logic [31:0]      rd_dat_q, rd_dat_d;
    logic             sram_rd_en_q, sram_rd_en_d;
    logic             sram_wr_en_q, sram_wr_en_d;
    logic [ADR_W-1:0] sram_adr_q, sram_adr_d;
    logic [3:0]       wr_sel_q, wr_sel_d;
    logic [31:0]      wr_dat_q, wr_dat_d;

    logic        rd_cmd, wr_cmd, win_hit, rd_done;
    logic [31:0] win_rdata;
    logic        unused_adr;

    assign rd_cmd     = cmd_val & ~cmd_we;
    assign wr_cmd     = cmd_val & cmd_we;
    assign rd_done    = (state_q == S_RD_WAIT) && (cnt_q == 3'd0);
    // Upper address bits only alias onto the array.
    assign unused_adr = ^{cmd_adr[31:ADR_W+2], cmd_adr[1:0]};

`ifdef TOYSRAM_CFG_REGS_EN
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;

    assign win_hit = (cmd_adr[27:24] == 4'hF);

    always_comb begin
        win_rdata = 32'h0;
        case (cmd_adr[3:2])
            2'd0:    win_rdata = 32'h5453_524D;
            2'd1:    win_rdata = scratch_q;
            2'd2:    win_rdata = rd_cnt_q;
            default: win_rdata = 32'h0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        rd_cnt_d  = rd_cnt_q;
        if (wr_cmd && win_hit && cmd_adr[3:2] == 2'd1) begin
            for (int b = 0; b < 4; b++) begin
                if (cmd_sel[b]) scratch_d[8*b +: 8] = cmd_dat[8*b +: 8];
            end
        end
        if (rd_done) rd_cnt_d = rd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= 32'h0;
            rd_cnt_q  <= 32'h0;
        end else begin
            scratch_q <= scratch_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end
`else
    assign win_hit   = 1'b0;
    assign win_rdata = 32'h0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_ack_d     = 1'b0;
        rd_dat_d     = rd_dat_q;
        sram_rd_en_d = 1'b0;
        sram_wr_en_d = 1'b0;
        sram_adr_d   = sram_adr_q;
        wr_sel_d     = wr_sel_q;
        wr_dat_d     = wr_dat_q;

        // Writes bypass the FSM; bridge duplicates are simply re-issued.
        if (wr_cmd && !win_hit) begin
            sram_wr_en_d = 1'b1;
            sram_adr_d   = cmd_adr[ADR_W+1:2];
            wr_sel_d     = cmd_sel;
            wr_dat_d     = cmd_dat;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_cmd) begin
                    if (win_hit) begin
                        rd_ack_d = 1'b1;
                        rd_dat_d = win_rdata;
                        state_d  = S_DRAIN;
                        cnt_d    = DRAIN_LD;
                    end else begin
                        sram_rd_en_d = 1'b1;
                        sram_adr_d   = cmd_adr[ADR_W+1:2];
                        state_d      = S_RD_WAIT;
                        cnt_d        = LAT_LD;
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rd_ack_d = 1'b1;
                    rd_dat_d = sram_rd_dat;
                    state_d  = S_DRAIN;
                    cnt_d    = DRAIN_LD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            // Entered in the ack cycle; the two following duplicate cycles are swallowed.
            S_DRAIN: begin
                if (cnt_q == 3'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            rd_ack_q     <= 1'b0;
            rd_dat_q     <= 32'h0;
            sram_rd_en_q <= 1'b0;
            sram_wr_en_q <= 1'b0;
            sram_adr_q   <= '0;
            wr_sel_q     <= 4'h0;
            wr_dat_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_ack_q     <= rd_ack_d;
            rd_dat_q     <= rd_dat_d;
            sram_rd_en_q <= sram_rd_en_d;
            sram_wr_en_q <= sram_wr_en_d;
            sram_adr_q   <= sram_adr_d;
            wr_sel_q     <= wr_sel_d;
            wr_dat_q     <= wr_dat_d;
        end
    end

    assign rd_ack      = rd_ack_q;
    assign rd_dat      = rd_dat_q;
    assign sram_rd_en  = sram_rd_en_q;
    assign sram_wr_en  = sram_wr_en_q;
    assign sram_adr    = sram_adr_q;
    assign sram_wr_sel = wr_sel_q;
    assign sram_wr_dat = wr_dat_q;

endmodule

// File: tb/tb_wb_cmd_ctl.sv
// Bench for wb_cmd_ctl: RD_LAT=2 instance driven from a vector table with a scoreboard,
// plus an RD_LAT=7 instance for the back-to-back read spacing case.
module tb_wb_cmd_ctl;

    localparam int ADR_W   = 10;
    localparam int RD_LAT2 = 2;
`ifdef TOYSRAM_CFG_REGS_EN
    localparam bit CFG = 1'b1;
`else
    localparam bit CFG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c_val = 1'b0, c_we = 1'b0, use7 = 1'b0;
    logic [31:0] c_adr = 32'h0, c_dat = 32'h0;
    logic [3:0]  c_sel = 4'h0;
    logic val2, val7;
    assign val2 = c_val & ~use7;
    assign val7 = c_val & use7;

    logic             rd_ack, sram_rd_en, sram_wr_en;
    logic [31:0]      rd_dat, sram_wr_dat, sram_rd_dat;
    logic [ADR_W-1:0] sram_adr;
    logic [3:0]       sram_wr_sel;
    logic             rd_ack7, sram_rd_en7, sram_wr_en7;
    logic [31:0]      rd_dat7, sram_wr_dat7, sram_rd_dat7;
    logic [ADR_W-1:0] sram_adr7;
    logic [3:0]       sram_wr_sel7;

    wb_cmd_ctl #(.ADR_W(ADR_W), .RD_LAT(RD_LAT2)) dut (
        .clk(clk), .rst(rst), .cmd_val(val2), .cmd_adr(c_adr), .cmd_we(c_we),
        .cmd_sel(c_sel), .cmd_dat(c_dat), .rd_ack(rd_ack), .rd_dat(rd_dat),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_adr(sram_adr),
        .sram_wr_sel(sram_wr_sel), .sram_wr_dat(sram_wr_dat), .sram_rd_dat(sram_rd_dat)
    );

    wb_cmd_ctl #(.ADR_W(ADR_W), .RD_LAT(7)) dut7 (
        .clk(clk), .rst(rst), .cmd_val(val7), .cmd_adr(c_adr), .cmd_we(c_we),
        .cmd_sel(c_sel), .cmd_dat(c_dat), .rd_ack(rd_ack7), .rd_dat(rd_dat7),
        .sram_rd_en(sram_rd_en7), .sram_wr_en(sram_wr_en7), .sram_adr(sram_adr7),
        .sram_wr_sel(sram_wr_sel7), .sram_wr_dat(sram_wr_dat7), .sram_rd_dat(sram_rd_dat7)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared array model honouring byte enables; junk on the read bus when not due.
    logic [31:0] mem [0:1023];
    logic [31:0] p2 [0:1];
    logic [31:0] p7 [0:6];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (sram_wr_en)
            for (int b = 0; b < 4; b++)
                if (sram_wr_sel[b]) mem[sram_adr][8*b +: 8] <= sram_wr_dat[8*b +: 8];
        p2[0] <= sram_rd_en ? mem[sram_adr] : 32'hBAD0_0002;
        p2[1] <= p2[0];
        p7[0] <= sram_rd_en7 ? mem[sram_adr7] : 32'hBAD0_0007;
        for (int i = 1; i < 7; i++) p7[i] <= p7[i-1];
    end
    assign sram_rd_dat  = p2[1];
    assign sram_rd_dat7 = p7[6];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          hold;
        logic [31:0] exp;
    } vec_t;
    typedef struct { logic [31:0] dat; int cyc; } rexp_t;
    typedef struct { logic [ADR_W-1:0] adr; logic [3:0] sel; logic [31:0] dat; int cyc; } wexp_t;

    rexp_t sbq[$];
    wexp_t wq[$];
    int nvec = 0, nerr = 0;
    int rd_en_cnt = 0, n_sram_rd = 0;
    logic prev_ack = 1'b0;
    rexp_t mr;
    wexp_t mw;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic is_win(input logic [31:0] a);
        return CFG && (a[27:24] == 4'hF);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (sram_rd_en) rd_en_cnt <= rd_en_cnt + 1;
            if (rd_ack) begin
                chk("ack_back_to_back", 64'(prev_ack), 64'd0);
                chk("ack_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    mr = sbq.pop_front();
                    chk("rd_dat", 64'(rd_dat), 64'(mr.dat));
                    chk("ack_cycle", 64'(cyc), 64'(mr.cyc));
                end
            end
            if (sram_wr_en) begin
                chk("wr_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    mw = wq.pop_front();
                    chk("wr_adr", 64'(sram_adr), 64'(mw.adr));
                    chk("wr_sel", 64'(sram_wr_sel), 64'(mw.sel));
                    chk("wr_dat", 64'(sram_wr_dat), 64'(mw.dat));
                    chk("wr_cycle", 64'(cyc), 64'(mw.cyc));
                end
            end
        end
        prev_ack <= rd_ack;
    end

    task automatic apply(input vec_t v);
        int en0;
        rexp_t r;
        wexp_t w;
        en0 = rd_en_cnt;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            c_val = 1'b1; c_we = v.we; c_adr = v.adr; c_sel = v.sel; c_dat = v.dat;
            if (v.we && !is_win(v.adr)) begin
                w.adr = v.adr[ADR_W+1:2]; w.sel = v.sel; w.dat = v.dat; w.cyc = cyc + 1;
                wq.push_back(w);
            end
            if (!v.we && i == 0) begin
                r.dat = v.exp;
                r.cyc = cyc + (is_win(v.adr) ? 1 : RD_LAT2 + 2);
                sbq.push_back(r);
                if (!is_win(v.adr)) n_sram_rd++;
            end
        end
        @(posedge clk); #1;
        c_val = 1'b0;
        for (int t = 0; t < 40 && (sbq.size() != 0 || wq.size() != 0); t++) @(posedge clk);
        chk("drain_timeout", 64'(sbq.size() + wq.size()), 64'd0);
        repeat (3) @(posedge clk);
        chk("rd_en_count", 64'(rd_en_cnt - en0), (!v.we && !is_win(v.adr)) ? 64'd1 : 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
        chk({tag, "_rd_dat"}, 64'(rd_dat), 64'd0);
        chk({tag, "_sram_rd_en"}, 64'(sram_rd_en), 64'd0);
        chk({tag, "_sram_wr_en"}, 64'(sram_wr_en), 64'd0);
        chk({tag, "_sram_adr"}, 64'(sram_adr), 64'd0);
        chk({tag, "_sram_wr_sel"}, 64'(sram_wr_sel), 64'd0);
        chk({tag, "_sram_wr_dat"}, 64'(sram_wr_dat), 64'd0);
    endtask

    vec_t tbl[16];
    vec_t v;
    int   en0, acks, ens;
    int   en_cyc[4];
    int   ack_cyc[2];
    logic [31:0] ack_dat[2];

    initial begin
        tbl[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1, 32'h0};
        tbl[1]  = '{1'b0, 32'h10,       4'hF, 32'h0,        1, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h20,       4'hF, 32'hFFFFFFFF, 1, 32'h0};
        tbl[3]  = '{1'b1, 32'h20,       4'h5, 32'h11223344, 1, 32'h0};
        tbl[4]  = '{1'b0, 32'h20,       4'hF, 32'h0,        1, 32'hFF22FF44};
        tbl[5]  = '{1'b0, 32'h10,       4'hF, 32'h0,        6, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 32'h30,       4'h0, 32'h12345678, 1, 32'h0};
        tbl[7]  = '{1'b0, 32'h30,       4'hF, 32'h0,        1, 32'h0};
        tbl[8]  = '{1'b1, 32'h1040,     4'hF, 32'hCAFEF00D, 1, 32'h0};
        tbl[9]  = '{1'b0, 32'h40,       4'hF, 32'h0,        1, 32'hCAFEF00D};
        tbl[10] = '{1'b1, 32'h50,       4'hF, 32'h55AA55AA, 3, 32'h0};
        tbl[11] = '{1'b0, 32'h50,       4'hF, 32'h0,        2, 32'h55AA55AA};
        tbl[12] = '{1'b1, 32'h0,        4'hF, 32'h0BADF00D, 1, 32'h0};
        tbl[13] = '{1'b1, 32'h4,        4'hF, 32'h600DCAFE, 1, 32'h0};
        tbl[14] = '{1'b0, 32'h0F000000, 4'hF, 32'h0,        1, CFG ? 32'h5453524D : 32'h0BADF00D};
        tbl[15] = '{1'b0, 32'h4,        4'hF, 32'h0,        1, 32'h600DCAFE};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        for (int i = 0; i < 16; i++) apply(tbl[i]);

`ifdef TOYSRAM_CFG_REGS_EN
        apply('{1'b0, 32'h0F000004, 4'hF, 32'h0,        1, 32'h0});
        apply('{1'b1, 32'h0F000004, 4'hC, 32'hAABBCCDD, 1, 32'h0});
        apply('{1'b0, 32'h0F000004, 4'hF, 32'h0,        1, 32'hAABB0000});
        apply('{1'b1, 32'h0F00000C, 4'hF, 32'hFFFFFFFF, 1, 32'h0});
        apply('{1'b0, 32'h0F00000C, 4'hF, 32'h0,        1, 32'h0});
        v = '{1'b0, 32'h0F000008, 4'hF, 32'h0, 1, 32'(n_sram_rd)};
        apply(v);
`endif

        // Reset in the cycle after sram_rd_en abandons the read.
        en0 = rd_en_cnt;
        @(posedge clk); #1;
        c_val = 1'b1; c_we = 1'b0; c_adr = 32'h10; c_sel = 4'hF;
        @(posedge clk); #1;
        c_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midread_rst");
        repeat (12) @(posedge clk);
        chk("midread_rd_en_count", 64'(rd_en_cnt - en0), 64'd1);
        apply('{1'b0, 32'h10, 4'hF, 32'h0, 1, 32'hDEADBEEF});

        // RD_LAT=7: read 0 held until ack, then read 4 held until ack.
        use7 = 1'b1;
        acks = 0; ens = 0;
        for (int t = 0; t < 80 && acks < 2; t++) begin
            @(posedge clk); #1;
            c_val = 1'b1; c_we = 1'b0; c_sel = 4'hF;
            c_adr = (acks == 0) ? 32'h0 : 32'h4;
            @(negedge clk);
            if (sram_rd_en7) begin
                if (ens < 4) en_cyc[ens] = cyc;
                ens++;
            end
            if (rd_ack7) begin
                ack_cyc[acks] = cyc;
                ack_dat[acks] = rd_dat7;
                acks++;
            end
        end
        @(posedge clk); #1;
        c_val = 1'b0; use7 = 1'b0;
        chk("lat7_acks", 64'(acks), 64'd2);
        chk("lat7_rd_en_count", 64'(ens), 64'd2);
        chk("lat7_dat0", 64'(ack_dat[0]), 64'h0BADF00D);
        chk("lat7_dat1", 64'(ack_dat[1]), 64'h600DCAFE);
        chk("lat7_ack0_cycle", 64'(ack_cyc[0]), 64'(en_cyc[0] + 8));
        chk("lat7_rd_en_gap", 64'(en_cyc[1] >= ack_cyc[0] + 3), 64'd1);
        chk("lat7_ack1_cycle", 64'(ack_cyc[1]), 64'(en_cyc[1] + 8));

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sbq.size() + wq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wb_cmd_ctl.md
# wb_cmd_ctl

Command controller directly downstream of the Wishbone slave bridge. It consumes the registered command stream (cmd_val/adr/we/sel/dat) and issues fixed-latency accesses to the toy SRAM array. It returns read data to the bridge as a one-cycle rd_ack/rd_dat pulse. It filters the duplicate command cycles the bridge produces while the Wishbone master holds stb, so each read is issued to the array exactly once.

## Interface
- ADR_W, 10: SRAM word-address width.
- RD_LAT, 2: SRAM read latency in cycles from sram_rd_en to valid sram_rd_dat; legal range 1..7.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- cmd_val  in  1  command valid from the bridge; may repeat the same command on consecutive cycles.
- cmd_adr  in  32  byte address.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte-lane enables.
- cmd_dat  in  32  write data.
- rd_ack  out  1  read-complete pulse to the bridge.
- rd_dat  out  32  read data; held between pulses.
- sram_rd_en  out  1  array read strobe.
- sram_wr_en  out  1  array write strobe.
- sram_adr  out  ADR_W  word address, taken from cmd_adr[ADR_W+1:2].
- sram_wr_sel  out  4  byte-lane write enables.
- sram_wr_dat  out  32  array write data.
- sram_rd_dat  in  32  array read data, valid RD_LAT cycles after sram_rd_en.

## Operation
- States:
  - IDLE.
  - RD_WAIT: latency counter, 3 bits, loaded with RD_LAT.
  - DRAIN: 2-cycle counter.
- IDLE, cmd_val=1, cmd_we=0:
  - Register sram_rd_en, sram_adr.
  - Go to RD_WAIT.
  - Counter decrements once per cycle after sram_rd_en.
  - At 0, capture sram_rd_dat into rd_dat, pulse rd_ack, go to DRAIN.
- Register-window read (see Configuration): rd_ack next cycle, then DRAIN. No SRAM access.
- DRAIN: ignore cmd_val for exactly 2 cycles, then return to IDLE. These are the two trailing duplicate cycles of the just-acked read.
- RD_WAIT: read cmd_val cycles are ignored. They are duplicates.
- Writes (cmd_val=1, cmd_we=1):
  - Accepted in every state, with no backpressure. The bridge acks writes itself.
  - Registered sram_wr_en/adr/sel/dat are issued the next cycle.
  - Duplicate write cycles are re-issued. This is harmless because writes are idempotent.
- cmd_sel=0 on a write: sram_wr_en still pulses, with sram_wr_sel=0.
- cmd_adr bits above ADR_W+1 are ignored for SRAM decode. SRAM addresses alias.

## Timing
- Reset values: rd_ack=0, rd_dat=0, sram_rd_en=0, sram_wr_en=0, sram_adr=0, sram_wr_sel=0, sram_wr_dat=0, state IDLE, counters 0.
- SRAM read:
  - Command cycle N.
  - sram_rd_en high in cycle N+1 only.
  - sram_rd_dat sampled in cycle N+1+RD_LAT.
  - rd_ack high in cycle N+2+RD_LAT, 1 cycle.
- Register read: command cycle N, rd_ack in cycle N+1.
- Next read accepted no earlier than rd_ack cycle + 3.
- Write: command cycle N, sram_wr_en in cycle N+1, 1 cycle per accepted cmd_val.
- rst asserted mid-read: the read is abandoned. No rd_ack, and no late capture after rst deasserts.
- rd_ack is never high in consecutive cycles.

## Configuration
- Macro TOYSRAM_CFG_REGS_EN.
- Defined: cmd_adr[27:24]=4'hF selects a local register window (word index cmd_adr[3:2]), never the SRAM.
  - 0x0 ID: read-only, 32'h5453_524D.
  - 0x1 SCRATCH: read/write, byte-lane merge per cmd_sel, reset 0.
  - 0x2 RD_CNT: read-only count of completed SRAM reads, 32-bit wrap, reset 0.
  - 0x3: reads 0, writes ignored.
- Undefined: no window; every address decodes to the SRAM.

## Test plan
- RD_LAT=2: write 0xDEADBEEF at adr 0x10, sel=4'hF; then read 0x10 -> sram_wr_en once per write cycle; one sram_rd_en; rd_ack 4 cycles after the command with rd_dat=0xDEADBEEF.
- Read held on cmd_val for 6 cycles until ack -> exactly one sram_rd_en and one rd_ack; DRAIN swallows the 2 trailing cycles.
- Write 0x11223344 with sel=4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44, assuming an array model that honours byte enables.
- rst pulsed in the cycle after sram_rd_en -> no rd_ack afterwards; all outputs 0; next read completes normally.
- TOYSRAM_CFG_REGS_EN:
  - read 0xF000000 -> rd_ack next cycle, rd_dat=0x5453524D.
  - SCRATCH write 0xAABBCCDD with sel=4'b1100, then read -> 0xAABB0000.
  - RD_CNT after 3 SRAM reads -> 3.
- RD_LAT=7: back-to-back reads to adr 0 and 4 -> second sram_rd_en no earlier than 3 cycles after the first rd_ack; data is correct for each.
